// File: rtl/modport_axi_mem.sv
// AXI4-style slave endpoint with an internal word-addressed memory.
// Write (AW/W/B) and read (AR/R) channels run as independent FSMs sharing one array.
// FIXED and INCR bursts up to 2**ADDR_LEN beats; errors are reported per burst as SLVERR.
module modport_axi_mem #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_LEN   = 4,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    aw_avalid,
    output logic                    aw_aready,
    input  logic [ID_WIDTH-1:0]     aw_aid,
    input  logic [ADDR_WIDTH-1:0]   aw_aaddr,
    input  logic [ADDR_LEN-1:0]     aw_alen,
    input  logic [2:0]              aw_asize,
    input  logic [1:0]              aw_aburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    ar_avalid,
    output logic                    ar_aready,
    input  logic [ID_WIDTH-1:0]     ar_aid,
    input  logic [ADDR_WIDTH-1:0]   ar_aaddr,
    input  logic [ADDR_LEN-1:0]     ar_alen,
    input  logic [2:0]              ar_asize,
    input  logic [1:0]              ar_aburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);
    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SH   = $clog2(STRB_W);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * STRB_W;
    localparam int unsigned EXT_W     = ADDR_WIDTH + ADDR_LEN + 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Whole-burst error: unsupported burst type, oversize beat, or any beat past the array.
    // INCR addresses only grow, so checking the final beat covers every beat.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [ADDR_LEN-1:0]   len,
                                       input logic [2:0]            size,
                                       input logic [1:0]            burst);
        logic [EXT_W-1:0] last_addr;
        if (burst == BURST_INCR) begin
            last_addr = EXT_W'(addr) + (EXT_W'(len) << size);
        end else begin
            last_addr = EXT_W'(addr);
        end
        return burst[1] | (size > 3'(BYTE_SH)) | (last_addr >= EXT_W'(MEM_BYTES));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
        if (burst == BURST_INCR) begin
            return addr + (ADDR_WIDTH'(1) << size);
        end else begin
            return addr;
        end
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[BYTE_SH +: IDX_W];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write path state
    w_state_e              w_state_q, w_state_d;
    logic                  aw_aready_q, aw_aready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d, w_id_q, w_id_d;
    logic [1:0]            bresp_q, bresp_d, w_burst_q, w_burst_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_LEN-1:0]   w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic                  w_err_q, w_err_d, w_wlast_err_q, w_wlast_err_d;
    logic                  w_beat_s, w_final_s;

    // Read path state
    r_state_e              r_state_q, r_state_d;
    logic                  ar_aready_q, ar_aready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d, r_burst_q, r_burst_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_naddr_s;
    logic [ADDR_LEN-1:0]   r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_cnt_nxt_s;
    logic [2:0]            r_size_q, r_size_d;
    logic                  r_err_q, r_err_d, ar_err_s;

    // wid carries no meaning for this endpoint: write data follows the single open AW.
    logic unused_wid_s;
    assign unused_wid_s = ^wid;

    assign w_beat_s    = (w_state_q == W_DATA) & wvalid & wready_q;
    assign w_final_s   = (w_cnt_q == w_len_q);
    assign r_naddr_s   = next_addr(r_addr_q, r_size_q, r_burst_q);
    assign r_cnt_nxt_s = r_cnt_q + {{(ADDR_LEN-1){1'b0}}, 1'b1};
    assign ar_err_s    = burst_err(ar_aaddr, ar_alen, ar_asize, ar_aburst);

    // Write FSM next state; handshake outputs are registered decodes of the next state.
    always_comb begin
        w_state_d     = w_state_q;
        bid_d         = bid_q;
        bresp_d       = bresp_q;
        w_id_d        = w_id_q;
        w_addr_d      = w_addr_q;
        w_len_d       = w_len_q;
        w_size_d      = w_size_q;
        w_burst_d     = w_burst_q;
        w_cnt_d       = w_cnt_q;
        w_err_d       = w_err_q;
        w_wlast_err_d = w_wlast_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_avalid && aw_aready_q) begin
                    w_id_d        = aw_aid;
                    w_addr_d      = aw_aaddr;
                    w_len_d       = aw_alen;
                    w_size_d      = aw_asize;
                    w_burst_d     = aw_aburst;
                    w_cnt_d       = {ADDR_LEN{1'b0}};
                    w_err_d       = burst_err(aw_aaddr, aw_alen, aw_asize, aw_aburst);
                    w_wlast_err_d = 1'b0;
                    w_state_d     = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_beat_s) begin
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + {{(ADDR_LEN-1){1'b0}}, 1'b1};
                    if (w_final_s) begin
                        w_state_d = W_RESP;
                        bid_d     = w_id_q;
                        bresp_d   = (w_err_q || w_wlast_err_q || !wlast) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_wlast_err_d = w_wlast_err_q | wlast;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        aw_aready_d = (w_state_d == W_IDLE);
        wready_d    = (w_state_d == W_DATA);
        bvalid_d    = (w_state_d == W_RESP);
    end

    // Write path registers; rst_n is active-high here.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            w_state_q     <= W_IDLE;
            aw_aready_q   <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bid_q         <= {ID_WIDTH{1'b0}};
            bresp_q       <= 2'b00;
            w_id_q        <= {ID_WIDTH{1'b0}};
            w_addr_q      <= {ADDR_WIDTH{1'b0}};
            w_len_q       <= {ADDR_LEN{1'b0}};
            w_size_q      <= 3'b000;
            w_burst_q     <= 2'b00;
            w_cnt_q       <= {ADDR_LEN{1'b0}};
            w_err_q       <= 1'b0;
            w_wlast_err_q <= 1'b0;
        end else begin
            w_state_q     <= w_state_d;
            aw_aready_q   <= aw_aready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bid_q         <= bid_d;
            bresp_q       <= bresp_d;
            w_id_q        <= w_id_d;
            w_addr_q      <= w_addr_d;
            w_len_q       <= w_len_d;
            w_size_q      <= w_size_d;
            w_burst_q     <= w_burst_d;
            w_cnt_q       <= w_cnt_d;
            w_err_q       <= w_err_d;
            w_wlast_err_q <= w_wlast_err_d;
        end
    end

    // Byte-strobed memory write; erroneous bursts consume beats without touching the array.
    always_ff @(posedge clk) begin
        if (!rst_n && w_beat_s && !w_err_q) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next state; rdata is loaded from the array on AR accept and on each beat accept,
    // so a same-edge write is seen only by later beats (read-before-write).
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_avalid && ar_aready_q) begin
                    rid_d     = ar_aid;
                    r_addr_d  = ar_aaddr;
                    r_len_d   = ar_alen;
                    r_size_d  = ar_asize;
                    r_burst_d = ar_aburst;
                    r_cnt_d   = {ADDR_LEN{1'b0}};
                    r_err_d   = ar_err_s;
                    rresp_d   = ar_err_s ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = ar_err_s ? {DATA_WIDTH{1'b0}} : mem[word_idx(ar_aaddr)];
                    rlast_d   = (ar_alen == {ADDR_LEN{1'b0}});
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d  = r_naddr_s;
                        r_cnt_d   = r_cnt_nxt_s;
                        rdata_d   = r_err_q ? {DATA_WIDTH{1'b0}} : mem[word_idx(r_naddr_s)];
                        rlast_d   = (r_cnt_nxt_s == r_len_q);
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
        ar_aready_d = (r_state_d == R_IDLE);
        rvalid_d    = (r_state_d == R_DATA);
    end

    // Read path registers; rst_n is active-high here.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state_q   <= R_IDLE;
            ar_aready_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= {ID_WIDTH{1'b0}};
            rresp_q     <= 2'b00;
            rdata_q     <= {DATA_WIDTH{1'b0}};
            r_addr_q    <= {ADDR_WIDTH{1'b0}};
            r_len_q     <= {ADDR_LEN{1'b0}};
            r_size_q    <= 3'b000;
            r_burst_q   <= 2'b00;
            r_cnt_q     <= {ADDR_LEN{1'b0}};
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            ar_aready_q <= ar_aready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            r_size_q    <= r_size_d;
            r_burst_q   <= r_burst_d;
            r_cnt_q     <= r_cnt_d;
            r_err_q     <= r_err_d;
        end
    end

    assign aw_aready = aw_aready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign ar_aready = ar_aready_q;
    assign rvalid    = rvalid_q;
    assign rid       = rid_q;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rlast     = rlast_q;

endmodule

// File: tb/tb_modport_axi_mem.sv
// Scoreboard bench for modport_axi_mem: expected B and R results are queued as bursts are
// issued and popped as the DUT hands them over. Inputs are driven and outputs sampled on negedge.
module tb_modport_axi_mem;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam int LW = 4;

    logic          clk, rst_n;
    logic          aw_avalid, aw_aready, wvalid, wready, wlast, bvalid, bready;
    logic [IW-1:0] aw_aid, wid, bid, ar_aid, rid;
    logic [AW-1:0] aw_aaddr, ar_aaddr;
    logic [LW-1:0] aw_alen, ar_alen;
    logic [2:0]    aw_asize, ar_asize;
    logic [1:0]    aw_aburst, ar_aburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [7:0]    wstrb;
    logic          ar_avalid, ar_aready, rvalid, rready, rlast;

    modport_axi_mem dut (
        .clk(clk), .rst_n(rst_n),
        .aw_avalid(aw_avalid), .aw_aready(aw_aready), .aw_aid(aw_aid), .aw_aaddr(aw_aaddr),
        .aw_alen(aw_alen), .aw_asize(aw_asize), .aw_aburst(aw_aburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .ar_avalid(ar_avalid), .ar_aready(ar_aready), .ar_aid(ar_aid), .ar_aaddr(ar_aaddr),
        .ar_alen(ar_alen), .ar_asize(ar_asize), .ar_aburst(ar_aburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t        bq[$];
    r_exp_t        rq[$];
    logic [DW-1:0] model [256];
    logic [DW-1:0] wbuf [16];
    int            errors = 0;
    int            checks = 0;

    // Independent reference of the error rules: bad burst, oversize beat, any beat past 0x800.
    function automatic logic exp_err(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic          e;
        logic [AW-1:0] a;
        e = burst[1] || (size > 3'd3);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            if (a >= 32'h800) e = 1'b1;
            if (burst == 2'b01) a = a + (32'd1 << size);
        end
        return e;
    endfunction

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                            input int wlast_beat);
        logic          err;
        logic [AW-1:0] a;
        b_exp_t        e;
        int            t;
        err = exp_err(addr, len, size, burst);
        if (!err) begin
            a = addr;
            for (int i = 0; i <= int'(len); i++) begin
                for (int b = 0; b < 8; b++) if (strb[b]) model[a[10:3]][8*b +: 8] = wbuf[i][8*b +: 8];
                if (burst == 2'b01) a = a + (32'd1 << size);
            end
        end
        e.id = id;
        e.resp = (err || wlast_beat != int'(len)) ? 2'b10 : 2'b00;
        bq.push_back(e);
        @(negedge clk);
        aw_avalid = 1'b1; aw_aid = id; aw_aaddr = addr; aw_alen = len; aw_asize = size; aw_aburst = burst;
        t = 0;
        while (!aw_aready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin checks++; errors++; $display("FAIL aw_timeout id=%0d", id); end
        @(negedge clk);
        aw_avalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL w_latency wready=%b required 1", wready); end
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wid = id; wlast = (i == wlast_beat);
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin checks++; errors++; $display("FAIL w_timeout beat=%0d", i); end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL b_latency bvalid=%b required 1", bvalid); end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            checks++; errors++; $display("FAIL b_timeout id=%0d", id);
        end else begin
            e = bq.pop_front();
            checks++;
            if (bid !== e.id || bresp !== e.resp) begin
                errors++; $display("FAIL bresp id=%0d resp=%b required id=%0d resp=%b", bid, bresp, e.id, e.resp);
            end
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        logic          err, held;
        logic [AW-1:0] a;
        logic [DW-1:0] held_d;
        logic          held_l;
        r_exp_t        e;
        int            t, got;
        err = exp_err(addr, len, size, burst);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id; e.data = err ? 64'd0 : model[a[10:3]];
            e.resp = err ? 2'b10 : 2'b00; e.last = (i == int'(len));
            rq.push_back(e);
            if (burst == 2'b01) a = a + (32'd1 << size);
        end
        @(negedge clk);
        ar_avalid = 1'b1; ar_aid = id; ar_aaddr = addr; ar_alen = len; ar_asize = size; ar_aburst = burst;
        t = 0;
        while (!ar_aready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin checks++; errors++; $display("FAIL ar_timeout id=%0d", id); end
        @(negedge clk);
        ar_avalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL r_latency rvalid=%b required 1", rvalid); end
        got = 0; t = 0; held = 1'b0; held_d = 64'd0; held_l = 1'b0;
        while (got <= int'(len) && t < 200) begin
            rready = stall ? (t % 2 == 0) : 1'b1;
            if (held) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== held_d || rlast !== held_l) begin
                    errors++;
                    $display("FAIL r_stall_hold rvalid=%b rdata=%h rlast=%b required 1 %h %b", rvalid, rdata, rlast, held_d, held_l);
                end
            end
            if (rvalid && rready) begin
                e = rq.pop_front();
                checks++;
                if (rid !== e.id || rdata !== e.data || rresp !== e.resp || rlast !== e.last) begin
                    errors++;
                    $display("FAIL rbeat id=%0d data=%h resp=%b last=%b required id=%0d data=%h resp=%b last=%b",
                             rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
                end
                got++; held = 1'b0;
            end else if (rvalid) begin
                held = 1'b1; held_d = rdata; held_l = rlast;
            end else begin
                held = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        if (got <= int'(len)) begin checks++; errors++; $display("FAIL r_timeout got=%0d required %0d", got, len + 1); end
        checks++;
        if (ar_aready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL r_return ar_aready=%b rvalid=%b required 1 0", ar_aready, rvalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({aw_aready, wready, bvalid, ar_aready, rvalid, rlast} !== 6'b0 ||
            {bid, bresp, rid, rresp} !== 12'd0 || rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_state rdy/valid=%b bid=%0d bresp=%b rid=%0d rresp=%b rdata=%h required all 0",
                     {aw_aready, wready, bvalid, ar_aready, rvalid, rlast}, bid, bresp, rid, rresp, rdata);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (aw_aready !== 1'b1 || ar_aready !== 1'b1) begin
            errors++; $display("FAIL reset_exit aw_aready=%b ar_aready=%b required 1 1", aw_aready, ar_aready);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h11 * 64'(i + 1);
        do_write(4'd3, 32'h40, 4'd3, 3'd3, 2'b01, 8'hFF, 3);
        do_read(4'd3, 32'h40, 4'd3, 3'd3, 2'b01, 1'b0);
    endtask

    task automatic test_strobe();
        wbuf[0] = 64'd0;
        do_write(4'd5, 32'h0, 4'd0, 3'd3, 2'b01, 8'hFF, 0);
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(4'd5, 32'h0, 4'd0, 3'd3, 2'b01, 8'h0F, 0);
        do_read(4'd6, 32'h0, 4'd0, 3'd3, 2'b01, 1'b0);
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hA000 + 64'(i);
        do_write(4'd1, 32'h180, 4'd3, 3'd3, 2'b00, 8'hFF, 3);
        do_read(4'd1, 32'h180, 4'd1, 3'd3, 2'b00, 1'b0);
    endtask

    task automatic test_rready_stall();
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hDEAD_0000_0000_0000 + 64'(i * 7 + 1);
        do_write(4'd2, 32'h100, 4'd3, 3'd3, 2'b01, 8'hFF, 3);
        do_read(4'd2, 32'h100, 4'd3, 3'd3, 2'b01, 1'b1);
    endtask

    task automatic test_errors();
        wbuf[0] = 64'h1234_5678_9ABC_DEF0;
        do_write(4'd4, 32'h200, 4'd0, 3'd3, 2'b01, 8'hFF, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hBAD0 + 64'(i);
        do_write(4'd4, 32'h200, 4'd0, 3'd3, 2'b10, 8'hFF, 0);
        do_read(4'd8, 32'h200, 4'd0, 3'd3, 2'b01, 1'b0);
        do_read(4'd8, 32'h200, 4'd1, 3'd3, 2'b10, 1'b0);
        do_write(4'd9, 32'h800, 4'd1, 3'd3, 2'b01, 8'hFF, 1);
        do_read(4'd9, 32'h800, 4'd1, 3'd3, 2'b01, 1'b0);
        do_read(4'd10, 32'h200, 4'd0, 3'd4, 2'b01, 1'b0);
        do_write(4'd11, 32'h300, 4'd3, 3'd3, 2'b01, 8'hFF, 1);
        do_write(4'd12, 32'h340, 4'd1, 3'd3, 2'b01, 8'hFF, 99);
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h4400 + 64'(i);
        do_write(4'd6, 32'h400, 4'd3, 3'd3, 2'b01, 8'hFF, 3);
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h5500 + 64'(i);
        fork
            do_write(4'd7, 32'h500, 4'd3, 3'd3, 2'b01, 8'hFF, 3);
            do_read(4'd9, 32'h400, 4'd3, 3'd3, 2'b01, 1'b0);
        join
        do_read(4'd7, 32'h500, 4'd3, 3'd3, 2'b01, 1'b0);
        do_read(4'd13, 32'h40, 4'd1, 3'd3, 2'b01, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        aw_avalid = 1'b1; aw_aid = 4'd14; aw_aaddr = 32'h600; aw_alen = 4'd3; aw_asize = 3'd3; aw_aburst = 2'b01;
        ar_avalid = 1'b1; ar_aid = 4'd15; ar_aaddr = 32'h40;  ar_alen = 4'd3; ar_asize = 3'd3; ar_aburst = 2'b01;
        @(negedge clk);
        aw_avalid = 1'b0; ar_avalid = 1'b0;
        wvalid = 1'b1; wdata = 64'h77; wstrb = 8'hFF; wlast = 1'b0; rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || wready !== 1'b1) begin
            errors++; $display("FAIL midburst_active rvalid=%b wready=%b required 1 1", rvalid, wready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; rready = 1'b0;
        checks++;
        if ({rvalid, wready, bvalid, rlast, aw_aready, ar_aready} !== 6'b0) begin
            errors++; $display("FAIL midburst_reset flags=%b required 000000", {rvalid, wready, bvalid, rlast, aw_aready, ar_aready});
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (aw_aready !== 1'b1 || ar_aready !== 1'b1 || rvalid !== 1'b0 || wready !== 1'b0) begin
            errors++; $display("FAIL midburst_idle aw_aready=%b ar_aready=%b rvalid=%b wready=%b required 1 1 0 0",
                               aw_aready, ar_aready, rvalid, wready);
        end
        do_read(4'd15, 32'h40, 4'd3, 3'd3, 2'b01, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 64'd0;
        rst_n = 1'b1; aw_avalid = 1'b0; wvalid = 1'b0; bready = 1'b0; ar_avalid = 1'b0; rready = 1'b0;
        aw_aid = '0; aw_aaddr = '0; aw_alen = '0; aw_asize = '0; aw_aburst = '0;
        ar_aid = '0; ar_aaddr = '0; ar_alen = '0; ar_asize = '0; ar_aburst = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_fixed();
        test_rready_stall();
        test_errors();
        test_concurrent();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
